// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: CPU-facing MMIO register block between the core bus and the
// UART TX/RX FIFOs. Single-cycle requests, read response one cycle later.
// Optional build macro: UART_MMIO_IRQ_EN enables the registered interrupt
// output; without it irq is tied low and the CTRL enable bits are storage only.
module uart_mmio_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic                  tx_wr_en,
  output logic [DATA_WIDTH-1:0] tx_din,
  input  logic                  tx_full,
  input  logic                  tx_empty,
  output logic                  rx_rd_en,
  input  logic [DATA_WIDTH-1:0] rx_dout,
  input  logic                  rx_empty,
  input  logic                  rx_drop,
  output logic                  start_tx,
  output logic                  irq
);

  localparam logic [2:0] A_RX   = 3'd0;
  localparam logic [2:0] A_TX   = 3'd1;
  localparam logic [2:0] A_STAT = 3'd2;
  localparam logic [2:0] A_CNT  = 3'd3;
  localparam logic [2:0] A_CTRL = 3'd4;

  logic                 rd_req, wr_req, cnt_clr;
  logic [31:0]          rd_val, rx_word;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 pop_q, pop_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 tx_drop_q, tx_drop_d;
  logic                 start_q, start_d;
  logic                 rx_ie_q, rx_ie_d;
  logic                 tx_ie_q, tx_ie_d;
  logic [CNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic                 unused_wdata;

  assign rd_req  = req & ~we;
  assign wr_req  = req & we;
  assign cnt_clr = wr_req & (addr == A_CTRL) & wdata[31];

  // FIFO strobes are combinational in the request cycle; gating with rst_n
  // makes them drop the moment reset asserts, even with req still high.
  assign tx_wr_en = rst_n & wr_req & (addr == A_TX) & ~tx_full;
  assign tx_din   = wdata[DATA_WIDTH-1:0];
  assign rx_rd_en = rst_n & rd_req & (addr == A_RX) & ~rx_empty;

  // RX FIFO output is registered, so the popped byte only exists in the
  // response cycle; it is muxed straight onto rdata there.
  assign rx_word  = 32'(rx_dout) | 32'h8000_0000;
  assign rdata    = pop_q ? rx_word : rdata_q;
  assign rvalid   = rvalid_q;
  assign start_tx = start_q;

  assign unused_wdata = ^wdata;

  // Read mux: STATUS/COUNT/CTRL are sampled in the request cycle.
  always_comb begin
    rd_val = 32'h0;
    case (addr)
      A_STAT:  rd_val = {27'b0, tx_drop_q, rx_ovr_q, tx_empty, tx_full, ~rx_empty};
      A_CNT:   rd_val = 32'({rx_cnt_q, tx_cnt_q});
      A_CTRL:  rd_val = {29'b0, tx_ie_q, rx_ie_q, start_q};
      default: rd_val = 32'h0;
    endcase
  end

  // Next-state for flags, counters, control and read response.
  always_comb begin
    rdata_d   = rdata_q;
    rvalid_d  = rd_req;
    pop_d     = rx_rd_en;
    rx_ovr_d  = rx_ovr_q;
    tx_drop_d = tx_drop_q;
    start_d   = start_q;
    rx_ie_d   = rx_ie_q;
    tx_ie_d   = tx_ie_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;

    // A new read owns the response register; otherwise latch the popped byte
    // so rdata keeps showing it after rvalid falls.
    if (rd_req)     rdata_d = rd_val;
    else if (pop_q) rdata_d = rx_word;

    // Clears first, then sets, so a same-cycle set event wins over W1C.
    if (wr_req && addr == A_STAT && wdata[3]) rx_ovr_d  = 1'b0;
    if (wr_req && addr == A_STAT && wdata[4]) tx_drop_d = 1'b0;
    if (rx_drop)                              rx_ovr_d  = 1'b1;
    if (wr_req && addr == A_TX && tx_full)    tx_drop_d = 1'b1;

    if (wr_req && addr == A_CTRL) begin
      start_d = wdata[0];
      rx_ie_d = wdata[1];
      tx_ie_d = wdata[2];
    end

    if (tx_wr_en) tx_cnt_d = tx_cnt_q + CNT_WIDTH'(1);
    if (rx_rd_en) rx_cnt_d = rx_cnt_q + CNT_WIDTH'(1);
    if (cnt_clr) begin
      tx_cnt_d = '0;
      rx_cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= 32'h0;
      rvalid_q  <= 1'b0;
      pop_q     <= 1'b0;
      rx_ovr_q  <= 1'b0;
      tx_drop_q <= 1'b0;
      start_q   <= 1'b0;
      rx_ie_q   <= 1'b0;
      tx_ie_q   <= 1'b0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
    end else begin
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      pop_q     <= pop_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_drop_q <= tx_drop_d;
      start_q   <= start_d;
      rx_ie_q   <= rx_ie_d;
      tx_ie_q   <= tx_ie_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty) | rx_ovr_q | tx_drop_q;
  assign irq   = irq_q;

  // Interrupt is registered: one cycle behind its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: directed vector table, reset and
// counter corner sequences, then random accesses against a behavioural model.
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;
  logic        rvalid, tx_wr_en, tx_full, tx_empty, rx_rd_en, rx_empty, rx_drop;
  logic [7:0]  tx_din, rx_dout;
  logic        start_tx, irq;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [15:0] m_tx, m_rx;
  logic        m_ovr, m_txd, m_start, m_rxie, m_txie;
  logic [31:0] m_last;

  uart_mmio_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .tx_wr_en(tx_wr_en), .tx_din(tx_din),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_rd_en(rx_rd_en), .rx_dout(rx_dout),
    .rx_empty(rx_empty), .rx_drop(rx_drop), .start_tx(start_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tx = 0; m_rx = 0; m_ovr = 0; m_txd = 0;
    m_start = 0; m_rxie = 0; m_txie = 0; m_last = 0;
  endtask

  // One bus access; entered and left 2 time units after a rising edge.
  task automatic access(input logic w, input logic [2:0] a, input logic [31:0] d,
                        input logic full, input logic tempty, input logic rempty,
                        input logic drop, input logic [7:0] rxb);
    logic [31:0] ev;
    logic        e_wr, e_pop, e_irq;
    req = 1; we = w; addr = a; wdata = d;
    tx_full = full; tx_empty = tempty; rx_empty = rempty; rx_drop = drop;
    e_wr  = w && a == 3'd1 && !full;
    e_pop = !w && a == 3'd0 && !rempty;
    case (a)
      3'd0:    ev = rempty ? 32'h0 : (32'h8000_0000 + 32'(rxb));
      3'd2:    ev = 32'(m_txd) * 16 + 32'(m_ovr) * 8 + 32'(tempty) * 4 + 32'(full) * 2 + 32'(!rempty);
      3'd3:    ev = 32'(m_rx) * 65536 + 32'(m_tx);
      3'd4:    ev = 32'(m_txie) * 4 + 32'(m_rxie) * 2 + 32'(m_start);
      default: ev = 32'h0;
    endcase
    e_irq = (m_rxie && !rempty) || (m_txie && tempty) || m_ovr || m_txd;
    #2;
    chk("tx_wr_en", 32'(tx_wr_en), 32'(e_wr));
    chk("rx_rd_en", 32'(rx_rd_en), 32'(e_pop));
    if (e_wr) chk("tx_din", 32'(tx_din), 32'(d[7:0]));
    @(posedge clk); #1;
    req = 0; we = 0; rx_drop = 0;
    if (e_pop) rx_dout = rxb;
    #1;
    // model update: clears before sets, counter clear last
    if (w) begin
      case (a)
        3'd1: if (full) m_txd = 1; else m_tx = m_tx + 16'd1;
        3'd2: begin if (d[3]) m_ovr = 0; if (d[4]) m_txd = 0; end
        3'd4: begin m_start = d[0]; m_rxie = d[1]; m_txie = d[2]; end
        default: ;
      endcase
    end
    if (e_pop) m_rx = m_rx + 16'd1;
    if (drop) m_ovr = 1;
    if (w && a == 3'd4 && d[31]) begin m_tx = 0; m_rx = 0; end
    if (!w) m_last = ev;
    chk("rvalid", 32'(rvalid), 32'(!w));
    chk("rdata", rdata, m_last);
    chk("start_tx", 32'(start_tx), 32'(m_start));
`ifdef UART_MMIO_IRQ_EN
    chk("irq", 32'(irq), 32'(e_irq));
`else
    chk("irq_tied", 32'(irq), 32'(1'b0 && e_irq));
`endif
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    logic        full, tempty, rempty, drop;
    logic [7:0]  rxb;
    logic        chk_rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    rst_n = 0; req = 0; we = 0; addr = 0; wdata = 0;
    tx_full = 0; tx_empty = 0; rx_empty = 1; rx_drop = 0; rx_dout = 0;
    model_reset();

    // directed table: w, a, d, full, tempty, rempty, drop, rxb, chk, exp
    vt.push_back('{1, 1, 32'h41,        0, 0, 1, 0, 8'h00, 0, 32'h0});
    vt.push_back('{1, 1, 32'h42,        0, 0, 1, 0, 8'h00, 0, 32'h0});
    vt.push_back('{0, 3, 32'h0,         0, 0, 1, 0, 8'h00, 1, 32'h0000_0002});
    vt.push_back('{1, 1, 32'h55,        1, 0, 1, 0, 8'h00, 0, 32'h0});
    vt.push_back('{0, 2, 32'h0,         1, 0, 1, 0, 8'h00, 1, 32'h0000_0012});
    vt.push_back('{1, 2, 32'h10,        0, 1, 1, 0, 8'h00, 0, 32'h0});
    vt.push_back('{0, 2, 32'h0,         0, 1, 1, 0, 8'h00, 1, 32'h0000_0004});
    vt.push_back('{0, 0, 32'h0,         0, 1, 0, 0, 8'hA5, 1, 32'h8000_00A5});
    vt.push_back('{0, 0, 32'h0,         0, 1, 1, 0, 8'h00, 1, 32'h0000_0000});
    vt.push_back('{0, 3, 32'h0,         0, 1, 1, 0, 8'h00, 1, 32'h0001_0002});
    vt.push_back('{1, 2, 32'h08,        0, 1, 1, 1, 8'h00, 0, 32'h0});
    vt.push_back('{0, 2, 32'h0,         0, 1, 1, 0, 8'h00, 1, 32'h0000_000C});
    vt.push_back('{1, 2, 32'h08,        0, 1, 1, 0, 8'h00, 0, 32'h0});
    vt.push_back('{0, 2, 32'h0,         0, 1, 1, 0, 8'h00, 1, 32'h0000_0004});
    vt.push_back('{1, 4, 32'h8000_0001, 0, 1, 1, 0, 8'h00, 0, 32'h0});
    vt.push_back('{0, 4, 32'h0,         0, 1, 1, 0, 8'h00, 1, 32'h0000_0001});
    vt.push_back('{0, 3, 32'h0,         0, 1, 1, 0, 8'h00, 1, 32'h0000_0000});
    vt.push_back('{1, 5, 32'hFFFF_FFFF, 0, 1, 1, 0, 8'h00, 0, 32'h0});
    vt.push_back('{0, 5, 32'h0,         0, 1, 1, 0, 8'h00, 1, 32'h0000_0000});
    vt.push_back('{1, 3, 32'hFFFF_FFFF, 0, 1, 1, 0, 8'h00, 0, 32'h0});
    vt.push_back('{0, 3, 32'h0,         0, 1, 1, 0, 8'h00, 1, 32'h0000_0000});

    // reset values while held in reset
    #3;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_start_tx", 32'(start_tx), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(posedge clk); #2;
    rst_n = 1;
    @(posedge clk); #2;

    foreach (vt[i]) begin
      access(vt[i].w, vt[i].a, vt[i].d, vt[i].full, vt[i].tempty, vt[i].rempty,
             vt[i].drop, vt[i].rxb);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp);
    end

    // cnt_clr right behind a TX push: both counters end at 0, bit31 reads 0
    access(0, 0, 0, 0, 1, 0, 0, 8'h3C);
    access(1, 1, 32'h77, 0, 0, 1, 0, 8'h00);
    access(1, 4, 32'h8000_0000, 0, 0, 1, 0, 8'h00);
    access(0, 3, 0, 0, 0, 1, 0, 8'h00);
    chk("clr_count", rdata, 32'h0);
    access(0, 4, 0, 0, 0, 1, 0, 8'h00);
    chk("clr_ctrl_bit31", 32'(rdata[31]), 32'h0);

    // tx counter wrap
    for (int i = 0; i < 65535; i++) access(1, 1, 32'(i), 0, 0, 1, 0, 8'h00);
    access(0, 3, 0, 0, 0, 1, 0, 8'h00);
    chk("wrap_ffff", rdata, 32'h0000_FFFF);
    access(1, 1, 32'h5A, 0, 0, 1, 0, 8'h00);
    access(0, 3, 0, 0, 0, 1, 0, 8'h00);
    chk("wrap_zero", rdata, 32'h0);

    // reset in the middle of traffic with a read response pending
    access(1, 4, 32'h7, 0, 0, 1, 0, 8'h00);
    req = 1; we = 0; addr = 3'd2; tx_full = 0; tx_empty = 0; rx_empty = 0;
    @(posedge clk); #1;
    chk("mid_rvalid_pre", 32'(rvalid), 32'h1);
    addr = 3'd0;
    #1;
    chk("mid_rx_rd_en_pre", 32'(rx_rd_en), 32'h1);
    rst_n = 0;
    #1;
    chk("mid_rvalid", 32'(rvalid), 32'h0);
    chk("mid_rx_rd_en", 32'(rx_rd_en), 32'h0);
    chk("mid_rdata", rdata, 32'h0);
    chk("mid_start_tx", 32'(start_tx), 32'h0);
    we = 1; addr = 3'd1;
    #1;
    chk("mid_tx_wr_en", 32'(tx_wr_en), 32'h0);
    req = 0; we = 0; rx_empty = 1;
    @(posedge clk); #2;
    rst_n = 1;
    model_reset();
    @(posedge clk); #2;
    access(0, 2, 0, 0, 0, 1, 0, 8'h00);
    chk("post_rst_status", rdata, 32'h0);
    access(0, 3, 0, 0, 0, 1, 0, 8'h00);
    chk("post_rst_count", rdata, 32'h0);
    access(0, 4, 0, 0, 0, 1, 0, 8'h00);
    chk("post_rst_ctrl", rdata, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[31] = 1'b0;
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), d,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
             8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
